// File: rtl/pipe_elastic_stage.sv
// Elastic in-order pipeline register between two core stages: DEPTH-entry
// circular buffer with valid/ready handshakes, synchronous flush and a zeroed bubble when empty.
module pipe_elastic_stage #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter bit FLUSH_EXTEND = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             flush_d_r;
    logic             eff_flush_s;
    logic             push_s;
    logic             pop_s;

    // DEPTH need not be a power of two, so wrap is an explicit compare.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? {PTR_W{1'b0}} : ptr + 1'b1;
    endfunction

    // Handshake qualifiers; in_ready never looks at out_ready.
    always_comb begin
        eff_flush_s = flush | (FLUSH_EXTEND & flush_d_r);
        in_ready    = !eff_flush_s && (count_r < DEPTH_C);
        out_valid   = (count_r != {CNT_W{1'b0}});
        push_s      = in_valid && in_ready;
        pop_s       = out_valid && out_ready && !eff_flush_s;
        full        = (count_r == DEPTH_C);
        count       = count_r;
    end

    // Head payload, masked so stale entries never leak out as a bubble.
    always_comb begin
        if (out_valid) begin
            out_data = mem_r[rd_ptr_r];
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

    // Pointer, occupancy and flush-history state; reset overrides flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            flush_d_r <= 1'b0;
        end else begin
            flush_d_r <= flush;
            if (eff_flush_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ptr_next(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_next(rd_ptr_r);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + 1'b1;
                    2'b01:   count_r <= count_r - 1'b1;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Payload storage, written only on an accepted beat.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: three configurations share one stimulus stream and
// each is checked against a shift-register queue model every cycle.
module tb_pipe_elastic_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  fl;
    logic [31:0] od  [3];
    logic [1:0]  cnt [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: entry 0 is always the head, pops shift everything down.
    logic [31:0] mq   [3][8];
    int          mcnt [3];
    bit          mfd  [3];

    always #5 clk = ~clk;

    pipe_elastic_stage #(.WIDTH(32), .DEPTH(2), .FLUSH_EXTEND(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .count(cnt[0]), .full(fl[0]));

    pipe_elastic_stage #(.WIDTH(32), .DEPTH(2), .FLUSH_EXTEND(1'b1)) u_fe (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .count(cnt[1]), .full(fl[1]));

    pipe_elastic_stage #(.WIDTH(32), .DEPTH(3), .FLUSH_EXTEND(1'b0)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .count(cnt[2]), .full(fl[2]));

    function automatic int depth_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic bit fe_of(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            bit eff;
            bit ev;
            eff = flush || (fe_of(i) && mfd[i]);
            ev  = (mcnt[i] > 0);
            chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!eff && (mcnt[i] < depth_of(i))));
            chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(ev));
            chk($sformatf("out_data[%0d]", i), od[i], ev ? mq[i][0] : 32'h0);
            chk($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(mcnt[i]));
            chk($sformatf("full[%0d]", i), 32'(fl[i]), 32'(mcnt[i] == depth_of(i)));
            chk($sformatf("count_bound[%0d]", i), 32'(int'(cnt[i]) <= depth_of(i)), 32'd1);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit eff;
            bit do_push;
            bit do_pop;
            eff = flush || (fe_of(i) && mfd[i]);
            if (!rst) begin
                mcnt[i] = 0;
                mfd[i]  = 1'b0;
            end else begin
                mfd[i] = flush;
                if (eff) begin
                    mcnt[i] = 0;
                end else begin
                    do_push = in_valid && (mcnt[i] < depth_of(i));
                    do_pop  = (mcnt[i] > 0) && out_ready;
                    if (do_pop) begin
                        for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                        mcnt[i]--;
                    end
                    if (do_push) begin
                        mq[i][mcnt[i]] = in_data;
                        mcnt[i]++;
                    end
                end
            end
        end
    endtask

    // Inputs are already applied at the falling edge; check, clock, update model.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit ordy, input bit fls);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fls;
        step();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            mfd[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_count", 32'(cnt[2]), 32'd0);

        // Streaming with downstream always ready.
        cycle(1'b1, 32'h1, 1'b1, 1'b0);
        chk("stream_1", od[0], 32'h1);
        cycle(1'b1, 32'h2, 1'b1, 1'b0);
        chk("stream_2", od[0], 32'h2);
        chk("stream_cnt", 32'(cnt[0]), 32'd1);
        cycle(1'b1, 32'h3, 1'b1, 1'b0);
        chk("stream_3", od[0], 32'h3);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_bubble", od[0], 32'h0);

        // Downstream stall fill, then release.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        chk("fill_full", 32'(fl[0]), 32'd1);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        chk("fill_c_dropped", 32'(cnt[0]), 32'd2);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        chk("release_b", od[0], 32'hB);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        chk("release_c", od[0], 32'hC);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 1.
        cycle(1'b1, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'h20, 1'b1, 1'b0);
        chk("pushpop_data", od[0], 32'h20);
        chk("pushpop_cnt", 32'(cnt[0]), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full; the flush-cycle beat must be dropped.
        cycle(1'b1, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'hFF, 1'b0, 1'b1);
        chk("flush_cnt", 32'(cnt[0]), 32'd0);
        chk("flush_data", od[0], 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Flush extension: beat one cycle after the pulse is dropped only with extension.
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        chk("ext_dropped", 32'(cnt[1]), 32'd0);
        chk("noext_taken", od[0], 32'h55);
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        chk("ext_after", od[1], 32'h66);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Pointer wrap on DEPTH=3, then reset with two entries held.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h100 + 32'(k), 1'b1, 1'b0);
            chk("wrap_order", od[2], 32'h100 + 32'(k));
        end
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(cnt[2]), 32'd2);
        rst = 1'b0;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("midrst_cnt", 32'(cnt[2]), 32'd0);
        chk("midrst_valid", 32'(ov[2]), 32'd0);
        chk("midrst_full", 32'(fl[0]), 32'd0);

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
        end
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
